// File: rtl/shift_reg_univ.sv
// ---------------------------------------------------------------------------
// shift_reg_univ
//   Parametrised universal shift register. Supports hold, shift right,
//   shift left and parallel load. It has serial I/O at both ends and a shift
//   counter that pulses `done` once every WIDTH shifts.
//
//   Optional feature macro: SHIFT_REG_UNIV_ROTATE_EN
//     When this macro is defined, the module gets a `rot` input. During a
//     shift with rot=1, the bit leaving one end re-enters at the other end,
//     and sin_l / sin_r are ignored.
//
//   Parameters
//     WIDTH      register width (>= 1)
//     RESET_VAL  value of q while reset is asserted
//     CW         counter width, max(1, clog2(WIDTH+1)) (derived)
//
//   Ports
//     clk     rising-edge clock
//     rst     asynchronous, active-high reset
//     en      clock enable; q and cnt hold when 0
//     mode    00 hold, 01 shift right, 10 shift left, 11 load
//     d       parallel load data
//     sin_l   serial in at MSB (shift right)
//     sin_r   serial in at LSB (shift left)
//     rot     rotate instead of serial in (macro only)
//     q, qn   register contents and its complement
//     sout_l  q[WIDTH-1]
//     sout_r  q[0]
//     cnt     shifts since last load/reset, wraps at WIDTH
//     done    one-cycle pulse after the WIDTH-th shift
// ---------------------------------------------------------------------------
module shift_reg_univ #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                CW        = ($clog2(WIDTH+1) < 1) ? 1 : $clog2(WIDTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_l,
  input  logic              sin_r,
`ifdef SHIFT_REG_UNIV_ROTATE_EN
  input  logic              rot,
`endif
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qn,
  output logic              sout_l,
  output logic              sout_r,
  output logic [CW-1:0]     cnt,
  output logic              done
);

  localparam logic [1:0]    MODE_HOLD = 2'b00;
  localparam logic [1:0]    MODE_SHR  = 2'b01;
  localparam logic [1:0]    MODE_SHL  = 2'b10;
  localparam logic [1:0]    MODE_LOAD = 2'b11;
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  // Bits entering each end on a shift. In rotate mode, these are the bits
  // leaving the opposite end.
  logic in_l, in_r;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
  assign in_l = rot ? q_q[0]       : sin_l;
  assign in_r = rot ? q_q[WIDTH-1] : sin_r;
`else
  assign in_l = sin_l;
  assign in_r = sin_r;
`endif

  // A one-bit register has no bits to keep. Both shift directions then
  // reduce to loading the incoming bit.
  logic [WIDTH-1:0] shr_v, shl_v;
  generate
    if (WIDTH == 1) begin : g_w1
      assign shr_v = in_l;
      assign shl_v = in_r;
    end else begin : g_wn
      assign shr_v = {in_l, q_q[WIDTH-1:1]};
      assign shl_v = {q_q[WIDTH-2:0], in_r};
    end
  endgenerate

  always_comb begin
    logic shifting;
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shifting = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHR:  begin q_d = shr_v; shifting = 1'b1; end
        MODE_SHL:  begin q_d = shl_v; shifting = 1'b1; end
        MODE_LOAD: begin q_d = d;     cnt_d = '0;      end
        default:   ;                  // MODE_HOLD
      endcase
    end
    // Left and right shifts advance the same word counter.
    if (shifting) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q      = q_q;
  assign qn     = ~q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign cnt    = cnt_q;
  assign done   = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Randomised and directed bench for shift_reg_univ (WIDTH=4, RESET_VAL=1010)
// against an integer-arithmetic reference model.
module tb_shift_reg_univ;
  localparam int         W   = 4;
  localparam logic [3:0] RV  = 4'b1010;
  localparam int         MSK = (1 << W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] d = 4'h0;
  logic       sin_l = 1'b0, sin_r = 1'b0;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
  logic       rot = 1'b0;
`endif
  logic [3:0] q, qn;
  logic       sout_l, sout_r, done;
  logic [2:0] cnt;

  shift_reg_univ #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r),
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    .rot(rot),
`endif
    .q(q), .qn(qn), .sout_l(sout_l), .sout_r(sout_r), .cnt(cnt), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state: register value, shifts in current word, pulse
  int mq   = 0;
  int mcnt = 0;
  int mdone = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".q"},      32'(q),      32'(mq));
    chk({tag, ".qn"},     32'(qn),     32'((~mq) & MSK));
    chk({tag, ".sout_l"}, 32'(sout_l), 32'((mq >> (W-1)) & 1));
    chk({tag, ".sout_r"}, 32'(sout_r), 32'(mq & 1));
    chk({tag, ".cnt"},    32'(cnt),    32'(mcnt));
    chk({tag, ".done"},   32'(done),   32'(mdone));
  endtask

  task automatic model_reset();
    mq = int'(RV); mcnt = 0; mdone = 0;
  endtask

  // Drive one cycle's inputs, take an edge, advance the model, compare.
  task automatic step(input string tag, input logic e, input logic [1:0] m,
                      input logic [3:0] dv, input logic sl, input logic sr,
                      input logic r);
    int shifted;
    int bit_in;
    en = e; mode = m; d = dv; sin_l = sl; sin_r = sr;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    rot = r;
`endif
    @(posedge clk);
    shifted = 0;
    mdone   = 0;
    if (e) begin
      if (m == 2'b01) begin
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        bit_in = r ? (mq & 1) : int'(sl);
`else
        bit_in = int'(sl) + 0 * int'(r);
`endif
        mq = (mq >> 1) | (bit_in << (W-1));
        shifted = 1;
      end else if (m == 2'b10) begin
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        bit_in = r ? ((mq >> (W-1)) & 1) : int'(sr);
`else
        bit_in = int'(sr);
`endif
        mq = ((mq << 1) & MSK) | bit_in;
        shifted = 1;
      end else if (m == 2'b11) begin
        mq = int'(dv);
        mcnt = 0;
      end
    end
    if (shifted != 0) begin
      mcnt++;
      if (mcnt == W) begin
        mcnt = 0;
        mdone = 1;
      end
    end
    #1;
    chk_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic rst_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_shr [4];
    logic [3:0] sout_pre [4];
    logic [3:0] strm;
    exp_shr  = '{4'b0110, 4'b0011, 4'b0001, 4'b0000};
    sout_pre = '{4'd1, 4'd0, 4'd1, 4'd1};
    strm     = 4'b1011;

    // Reset takes effect with no clock edge.
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst.q",  32'(q),   32'(4'b1010));
    chk("rst.qn", 32'(qn),  32'(4'b0101));
    chk("rst.cnt", 32'(cnt), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk_all("rst_hold");
    rst = 1'b0;

    // Load, then shift right 4 times with sin_l=0.
    step("load", 1, 2'b11, 4'b1101, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("shr.sout_r_pre", 32'(sout_r), 32'(sout_pre[i]));
      step("shr", 1, 2'b01, 4'hF, 0, 1, 0);
      chk("shr.q_const", 32'(q), 32'(exp_shr[i]));
      chk("shr.done_const", 32'(done), (i == 3) ? 32'd1 : 32'd0);
    end

    // Shift-left deserialise: stream 1,0,1,1 from 0000.
    for (int i = 3; i >= 0; i--) step("shl", 1, 2'b10, 4'h0, 1, strm[i], 0);
    chk("deser.q", 32'(q), 32'(4'b1011));
    chk("deser.cnt", 32'(cnt), 32'd0);
    chk("deser.done", 32'(done), 32'd1);

    // Enable/hold mid-word.
    step("hw.s", 1, 2'b01, 4'h0, 1, 0, 0);
    step("hw.s", 1, 2'b01, 4'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("hw.en0", 0, 2'b01, 4'h5, 1, 1, 0);
    for (int i = 0; i < 2; i++) step("hw.hold", 1, 2'b00, 4'h5, 1, 1, 0);
    chk("hw.cnt", 32'(cnt), 32'd2);
    step("hw.s", 1, 2'b10, 4'h0, 0, 1, 0);
    step("hw.s", 1, 2'b01, 4'h0, 1, 0, 0);
    chk("hw.done", 32'(done), 32'd1);

    // Reset mid-word discards the partial word.
    step("rm.s", 1, 2'b10, 4'h0, 0, 1, 0);
    step("rm.s", 1, 2'b10, 4'h0, 0, 1, 0);
    rst_pulse("rm.rst");
    for (int i = 0; i < 4; i++) begin
      step("rm.s4", 1, 2'b01, 4'h0, 1, 0, 0);
      chk("rm.done", 32'(done), (i == 3) ? 32'd1 : 32'd0);
    end

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    step("rot.load", 1, 2'b11, 4'b1001, 0, 0, 0);
    step("rot.l", 1, 2'b10, 4'h0, 0, 0, 1);
    chk("rot.l_q", 32'(q), 32'(4'b0011));
    step("rot.r", 1, 2'b01, 4'h0, 0, 0, 1);
    chk("rot.r1_q", 32'(q), 32'(4'b1001));
    step("rot.r", 1, 2'b01, 4'h0, 0, 0, 1);
    chk("rot.r2_q", 32'(q), 32'(4'b1100));
`endif

    // Random traffic with occasional async reset pulses.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) rst_pulse("rnd.rst");
      step("rnd", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal shift register: the next-generation successor of the single-bit D flip-flop storage cell.
- Adds width generalisation, asynchronous reset, clock enable, four operating modes, serial I/O at both ends and a shift counter with a word-complete pulse.
- Used as a serializer/deserializer and as a general storage register in datapath exercises.

Parameters:
- WIDTH, 8, register width in bits; legal range is WIDTH >= 1.
- RESET_VAL, 0, value loaded into q on reset; WIDTH bits wide.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  clock enable; when 0, q and cnt hold.
- mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input entering at the MSB during a shift right.
- sin_r  input  1  serial input entering at the LSB during a shift left.
- q  output  WIDTH  register contents.
- qn  output  WIDTH  bitwise complement of q (combinational from q).
- sout_l  output  1  q[WIDTH-1] (combinational).
- sout_r  output  1  q[0] (combinational).
- cnt  output  CW  shifts since the last load/reset; CW = max(1, $clog2(WIDTH+1)).
- done  output  1  one-cycle pulse when WIDTH shifts have completed.

Behaviour:
- Reset (rst=1, asynchronous, no clock needed): q=RESET_VAL, qn=~RESET_VAL, cnt=0, done=0. Registers stay in this state while rst is held.
- All other updates happen on the rising edge of clk, with a latency of one cycle.
- en=0: q and cnt hold; done is forced to 0 on that edge.
- en=1, mode=00: q and cnt hold; done<=0.
- en=1, mode=01 (shift right): q <= {sin_l, q[WIDTH-1:1]}. The bit shifted out was sout_r before the edge.
- en=1, mode=10 (shift left): q <= {q[WIDTH-2:0], sin_r}. The bit shifted out was sout_l before the edge.
- en=1, mode=11 (load): q <= d; cnt <= 0; done <= 0.
- WIDTH=1: both shift modes give q <= the respective serial input.
- Counter rules:
  - Any shift (mode 01 or 10, en=1) with cnt < WIDTH-1: cnt <= cnt+1, done <= 0.
  - Shift with cnt == WIDTH-1: cnt <= 0 (wrap), done <= 1 on the same edge.
  - Hold does not clear cnt.
  - Mixed left and right shifts count identically.
- done is high for exactly one cycle, after the edge that completes the WIDTH-th shift. Back-to-back words give a done pulse every WIDTH shifting cycles.
- Reset asserted mid-word: q, cnt and done go to their reset values immediately; the partial word is discarded.
- Reset release: the first edge at which rst=0 performs a normal operation.
- No X propagation from unused inputs: d is ignored unless mode=11, and sin_l/sin_r are ignored unless their shift mode is selected.

Optional Feature:
- Macro: SHIFT_REG_UNIV_ROTATE_EN.
- Defined: adds input port rot (1 bit). When rot=1 during a shift:
  - shift right: q <= {q[0], q[WIDTH-1:1]};
  - shift left: q <= {q[WIDTH-2:0], q[WIDTH-1]};
  - sin_l and sin_r are ignored.
  - cnt and done behave exactly as for a normal shift.
- rot has no effect in hold or load.
- Not defined: the rot port does not exist and shifts always take the serial inputs.

Test Plan:
- Reset: WIDTH=4, RESET_VAL=4'b1010. Assert rst mid-cycle with no clock edge -> q=1010, qn=0101, cnt=0, done=0 immediately.
- Load then shift right: load d=4'b1101, then 4 cycles of mode=01 with sin_l=0 -> q goes 0110, 0011, 0001, 0000; sout_r sequence before each edge is 1,0,1,1; done=1 only after the 4th edge; cnt goes 1, 2, 3, 0.
- Shift left deserialize: from q=0000, mode=10 with sin_r stream 1,0,1,1 -> q=1011; done pulses once; cnt=0.
- Enable/hold: mid-word at cnt=2, set en=0 for 3 cycles, then mode=00 for 2 cycles -> q and cnt unchanged, done=0; resuming with 2 shifts gives done=1.
- Reset mid-word: after 2 shifts, pulse rst -> q=RESET_VAL and cnt=0; a following 4-shift sequence still requires 4 full shifts for done.
- Rotate (macro defined): q=1001, rot=1, mode=10 for 1 cycle -> q=0011; mode=01 twice from 0011 -> 1001, then 1100.
